// File: rtl/pool_stream_ctrl.sv
// Streaming 2x2 / stride-2 max-pooling sequencer: raster-order pixels in,
// one pooled maximum per window out, valid/ready on both sides.
module pool_stream_ctrl #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IMG_W  = 4,
  parameter int unsigned IMG_H  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned PAIRS  = IMG_W / 2;
  localparam int unsigned PAIR_W = (IMG_W > 2) ? $clog2(PAIRS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} poolStateT;

  poolStateT         state, stateNext;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] lbuf [PAIRS];
  logic [PAIR_W-1:0] pairIdx;
  logic [DATA_W-1:0] pairMax, winMax;
  logic              inFire, outFire, lastPix, loadResult, doneNext;

  assign in_ready   = (state == RUN) && (!out_valid || out_ready);
  assign inFire     = in_valid && in_ready;
  assign outFire    = out_valid && out_ready;
  assign lastPix    = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign pairIdx    = PAIR_W'(col >> 1);
  assign pairMax    = (in_data > hold) ? in_data : hold;
  assign winMax     = (lbuf[pairIdx] > pairMax) ? lbuf[pairIdx] : pairMax;
  assign loadResult = inFire && col[0] && row[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    doneNext  = 1'b0;
    unique case (state)
      IDLE:  if (start) stateNext = RUN;
      RUN:   if (inFire && lastPix) stateNext = FLUSH;
      FLUSH: if (outFire) begin
        stateNext = IDLE;
        doneNext  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (inFire) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Partial maxima storage; contents only matter once written this frame
  always_ff @(posedge clk) begin
    if (inFire && !col[0]) hold <= in_data;
    if (inFire && col[0] && !row[0]) lbuf[pairIdx] <= pairMax;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (loadResult) begin
        out_valid <= 1'b1;
        out_data  <= winMax;
        out_last  <= lastPix;
      end else if (outFire) begin
        out_valid <= 1'b0;
      end
      busy <= (stateNext != IDLE);
      done <= doneNext;
    end
  end

endmodule

// File: tb/tb_pool_stream_ctrl.sv
// Bench for pool_stream_ctrl: a 4x4 and an 8x4 instance share stimulus,
// results compared with a window-max reference built from the frame pixels.
module tb_pool_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, inValid, outReady, sel;
  logic [3:0] inData;

  logic       inReadyA, outValidA, outLastA, busyA, doneA;
  logic [3:0] outDataA;
  logic       inReadyB, outValidB, outLastB, busyB, doneB;
  logic [3:0] outDataB;

  logic       inReady, outValid, outLast, busy, done;
  logic [3:0] outData;

  pool_stream_ctrl #(.DATA_W(4), .IMG_W(4), .IMG_H(4)) dutA (
    .clk(clk), .rst(rst), .start(start && !sel), .in_valid(inValid), .in_data(inData),
    .in_ready(inReadyA), .out_valid(outValidA), .out_data(outDataA), .out_last(outLastA),
    .out_ready(outReady), .busy(busyA), .done(doneA)
  );

  pool_stream_ctrl #(.DATA_W(4), .IMG_W(8), .IMG_H(4)) dutB (
    .clk(clk), .rst(rst), .start(start && sel), .in_valid(inValid), .in_data(inData),
    .in_ready(inReadyB), .out_valid(outValidB), .out_data(outDataB), .out_last(outLastB),
    .out_ready(outReady), .busy(busyB), .done(doneB)
  );

  assign inReady  = sel ? inReadyB  : inReadyA;
  assign outValid = sel ? outValidB : outValidA;
  assign outData  = sel ? outDataB  : outDataA;
  assign outLast  = sel ? outLastB  : outLastA;
  assign busy     = sel ? busyB     : busyA;
  assign done     = sel ? doneB     : doneA;

  int errors = 0;
  int checks = 0;
  int pix[$];
  int expq[$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Expected results: max over each 2x2 window, windows in raster order
  function automatic void buildExpected(input int w, input int h);
    expq.delete();
    for (int wr = 0; wr < h / 2; wr++)
      for (int wc = 0; wc < w / 2; wc++) begin
        int top = (2 * wr) * w + 2 * wc;
        int bot = top + w;
        expq.push_back(max2(max2(pix[top], pix[top + 1]), max2(pix[bot], pix[bot + 1])));
      end
  endfunction

  task automatic randomPixels(input int n, input bit saturate);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(saturate ? 15 : int'($urandom_range(15)));
  endtask

  task automatic nominalPixels();
    pix = '{2, 0, 2, 1, 6, 3, 8, 7, 3, 4, 0, 1, 2, 1, 5, 2};
  endtask

  // readyMode: 0 always ready, 1 random, 2 held low until 3 cycles after first out_valid
  task automatic runFrame(input int w, input int h, input bit doStart, input bit chainNext,
                          input int readyMode, input int validPct, input int midStart,
                          input int abortAt, input bit checkThru);
    int idx, cyc, lastOutCyc, firstValidCyc, firstAcc, lastAcc;
    bit doneSeen, midDone;
    idx = 0; cyc = 0; lastOutCyc = -10; firstValidCyc = -1; firstAcc = -1; lastAcc = -1;
    doneSeen = 1'b0; midDone = 1'b0;
    buildExpected(w, h);
    while (!doneSeen && cyc < 2000) begin
      @(negedge clk);
      start = doStart && (cyc == 0);
      if (midStart >= 0 && !midDone && idx == midStart) begin
        start = 1'b1;
        midDone = 1'b1;
      end
      inValid = (idx < pix.size()) && ($urandom_range(99) < validPct);
      inData  = (idx < pix.size()) ? 4'(pix[idx]) : 4'(0);
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = 1'($urandom_range(1));
        default: outReady = (firstValidCyc >= 0) && (cyc >= firstValidCyc + 3);
      endcase
      #1;
      if (doStart && cyc == 1) begin
        checkEq("rdy_after_start", inReady, 1);
        checkEq("busy_run", busy, 1);
      end
      if (outValid && firstValidCyc < 0) firstValidCyc = cyc;
      if (outValid) begin
        if (expq.size() == 0) checkEq("extra_out", outValid, 0);
        else if (!outReady) begin
          checkEq("hold_data", outData, expq[0]);
          checkEq("hold_last", outLast, expq.size() == 1);
          checkEq("stall_in", inReady, 0);
        end else begin
          checkEq("out_data", outData, expq[0]);
          checkEq("out_last", outLast, expq.size() == 1);
          void'(expq.pop_front());
          lastOutCyc = cyc;
        end
      end
      if (inValid && inReady) begin
        if (firstAcc < 0) firstAcc = cyc;
        lastAcc = cyc;
        idx++;
      end
      if (done) begin
        checkEq("done_cycle", cyc, lastOutCyc + 1);
        checkEq("done_empty", expq.size(), 0);
        checkEq("busy_fall", busy, 0);
        doneSeen = 1'b1;
        if (chainNext) start = 1'b1;
      end
      if (abortAt > 0 && idx == abortAt) break;
      cyc++;
    end
    if (abortAt == 0) begin
      checkEq("frame_done", doneSeen, 1);
      checkEq("pixels_used", idx, w * h);
      if (checkThru) checkEq("throughput", lastAcc - firstAcc, w * h - 1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_in_ready"}, inReady, 0);
    checkEq({tag, "_out_valid"}, outValid, 0);
    checkEq({tag, "_out_last"}, outLast, 0);
    checkEq({tag, "_busy"}, busy, 0);
    checkEq({tag, "_done"}, done, 0);
    checkEq({tag, "_out_data"}, outData, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst = 1'b1; start = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkResetOutputs("reset");
    @(negedge clk) rst = 1'b0;

    nominalPixels();
    runFrame(4, 4, 1'b1, 1'b0, 0, 100, -1, 0, 1'b1);
    runFrame(4, 4, 1'b1, 1'b0, 2, 100, -1, 0, 1'b0);
    runFrame(4, 4, 1'b1, 1'b0, 0, 100, 5, 0, 1'b0);

    runFrame(4, 4, 1'b1, 1'b1, 0, 100, -1, 0, 1'b0);
    randomPixels(16, 1'b0);
    runFrame(4, 4, 1'b0, 1'b0, 1, 70, -1, 0, 1'b0);

    nominalPixels();
    runFrame(4, 4, 1'b1, 1'b0, 0, 100, -1, 6, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    rst = 1'b1;
    #1 checkResetOutputs("midrst");
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 checkEq("post_rst_quiet", {outValid, done, busy}, 0);
    end
    runFrame(4, 4, 1'b1, 1'b0, 0, 100, -1, 0, 1'b1);

    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      randomPixels(32, 1'b0);
      runFrame(8, 4, 1'b1, 1'b0, 1, 50, -1, 0, 1'b0);
    end
    randomPixels(32, 1'b1);
    runFrame(8, 4, 1'b1, 1'b0, 1, 50, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
